// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencer: FSM encoding, default widths,
// and saturation limits for the default accumulator width.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 40;

  localparam logic [DEF_ACC_W-1:0] SAT_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic [DEF_ACC_W-1:0] SAT_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

endpackage

// File: rtl/mac_datapath.sv
// Product register and accumulator with overflow detection.
// MAC_SEQ_SATURATE_EN: clamp to signed max/min on overflow; otherwise wrap.
module mac_datapath
  import mac_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

`ifdef MAC_SEQ_SATURATE_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;
  logic [2*DATA_W-1:0] prod;
  logic                prod_valid;
  logic [ACC_W:0]      sum;
  logic                sum_ovf;
  logic [ACC_W-1:0]    acc_next;

  // One guard bit above the accumulator: overflow shows as guard != sign.
  always_comb begin
    a_ext    = {{DATA_W{data_a[DATA_W-1]}}, data_a};
    b_ext    = {{DATA_W{data_b[DATA_W-1]}}, data_b};
    sum      = {acc[ACC_W-1], acc}
             + {{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    sum_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
    acc_next = sum[ACC_W-1:0];
`ifdef MAC_SEQ_SATURATE_EN
    if (sum_ovf) begin
      acc_next = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
      ovf        <= 1'b0;
    end else begin
      prod_valid <= in_valid;
      if (in_valid) begin
        prod <= a_ext * b_ext;
      end
      if (clr) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (prod_valid) begin
        acc <= acc_next;
        if (sum_ovf) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: walks two RAM address streams and feeds mac_datapath.
// Saturation behaviour selected by MAC_SEQ_SATURATE_EN inside mac_datapath.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              we_a,
  output logic              we_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  acc_out,
  output logic              ovf
);

  state_t          state;
  logic [ADDR_W:0] remain;
  logic            drain_cnt;
  logic            rd_valid;
  logic            accept;

  assign we_a = 1'b0;
  assign we_b = 1'b0;

  // The done cycle is still part of the job, so a start there is ignored.
  assign accept = (state == ST_IDLE) && !done && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr_a    <= '0;
      addr_b    <= '0;
      remain    <= '0;
      drain_cnt <= 1'b0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_valid <= (state == ST_ISSUE);
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            busy <= 1'b1;
            if (len == '0) begin
              state <= ST_DONE;
            end else begin
              state  <= ST_ISSUE;
              addr_a <= base_a;
              addr_b <= base_b;
              remain <= len - (ADDR_W+1)'(1);
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (remain == '0) begin
            state     <= ST_DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            addr_a <= addr_a + ADDR_W'(1);
            addr_b <= addr_b + ADDR_W'(1);
            remain <= remain - (ADDR_W+1)'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) begin
            state <= ST_DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mac_datapath #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .in_valid(rd_valid),
    .data_a  (data_a),
    .data_b  (data_b),
    .acc     (acc_out),
    .ovf     (ovf)
  );

endmodule
